// File: rtl/qam_nmod_mapper.sv
// qam_nmod_mapper: serial-to-symbol QAM mapper with carrier multiply and I/Q sum.
// Optional feature macro: QAM_GRAY_EN (Gray-decode each axis code before amplitude mapping).
module qam_nmod_mapper #(
  parameter int unsigned BITS_PER_AXIS = 2,
  parameter int unsigned CAR_W         = 12,
  parameter int unsigned OUT_W         = CAR_W + BITS_PER_AXIS + 2,
  parameter bit          MSB_FIRST     = 1'b1
) (
  input  logic                     clk_16,
  input  logic                     rst_n,
  input  logic                     sync_clr,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  input  logic signed [CAR_W-1:0]  cos,
  input  logic signed [CAR_W-1:0]  sin,
  output logic [BITS_PER_AXIS-1:0] bitsa,
  output logic [BITS_PER_AXIS-1:0] bitsb,
  output logic                     sym_strobe,
  output logic signed [OUT_W-1:0]  acos,
  output logic signed [OUT_W-1:0]  bsin,
  output logic signed [OUT_W-1:0]  qam_out,
  output logic                     out_valid
);

  localparam int unsigned K       = BITS_PER_AXIS;
  localparam int unsigned SYM_W   = 2 * K;
  localparam int unsigned CNT_W   = $clog2(SYM_W);
  localparam int unsigned AMP_OFF = (2 ** K) - 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SYM_W - 1);

  // r_shift keeps the 2K-1 most recent bits; the completing bit is appended on the fly.
  logic [CNT_W-1:0]      r_cnt;
  logic [SYM_W-2:0]      r_shift;
  logic [SYM_W-1:0]      r_sym;
  logic                  r_load;
  logic [SYM_W-1:0]      w_shift_nxt;
  logic [K-1:0]          w_sym_i;
  logic [K-1:0]          w_sym_q;
  logic [K-1:0]          w_code_i;
  logic [K-1:0]          w_code_q;
  logic [K-1:0]          w_bin_a;
  logic [K-1:0]          w_bin_b;
  logic signed [K:0]     w_amp_a;
  logic signed [K:0]     w_amp_b;
  logic signed [OUT_W-1:0] w_acos;
  logic signed [OUT_W-1:0] w_bsin;
  logic signed [OUT_W-1:0] w_qam;

  assign w_shift_nxt = {r_shift, bit_in};
  assign w_sym_i     = r_sym[SYM_W-1:K];
  assign w_sym_q     = r_sym[K-1:0];

  // Bit collection; a completed symbol is parked in r_sym so a later clear cannot cancel its load.
  always_ff @(posedge clk_16 or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_sym   <= '0;
      r_load  <= 1'b0;
    end else begin
      r_load <= 1'b0;
      if (sync_clr) begin
        r_cnt   <= '0;
        r_shift <= '0;
      end else if (bit_valid) begin
        r_shift <= w_shift_nxt[SYM_W-2:0];
        if (r_cnt == LAST_CNT) begin
          r_cnt  <= '0;
          r_sym  <= w_shift_nxt;
          r_load <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Per-axis bit order: first received bit is the MSB, or the LSB when MSB_FIRST=0.
  always_comb begin
    w_code_i = w_sym_i;
    w_code_q = w_sym_q;
    if (!MSB_FIRST) begin
      for (int i = 0; i < int'(K); i++) begin
        w_code_i[i] = w_sym_i[int'(K) - 1 - i];
        w_code_q[i] = w_sym_q[int'(K) - 1 - i];
      end
    end
  end

  // Symbol hold registers and the one-cycle load strobe.
  always_ff @(posedge clk_16 or negedge rst_n) begin
    if (!rst_n) begin
      bitsa      <= '0;
      bitsb      <= '0;
      sym_strobe <= 1'b0;
    end else begin
      sym_strobe <= r_load;
      if (r_load) begin
        bitsa <= w_code_i;
        bitsb <= w_code_q;
      end
    end
  end

  // Axis code to natural binary index (Gray decode when enabled).
  always_comb begin
    w_bin_a = bitsa;
    w_bin_b = bitsb;
`ifdef QAM_GRAY_EN
    for (int i = 0; i < int'(K); i++) begin
      w_bin_a[i] = ^(bitsa >> i);
      w_bin_b[i] = ^(bitsb >> i);
    end
`else
`endif
  end

  // Odd-integer amplitude 2*code-(2^K-1), then full-precision carrier products.
  always_comb begin
    w_amp_a = $signed({w_bin_a, 1'b0} - (K + 1)'(AMP_OFF));
    w_amp_b = $signed({w_bin_b, 1'b0} - (K + 1)'(AMP_OFF));
    w_acos  = OUT_W'(w_amp_a) * OUT_W'(cos);
    w_bsin  = OUT_W'(w_amp_b) * OUT_W'(sin);
    w_qam   = w_acos - w_bsin;
  end

  // Product stage; outputs stay zero until the first loaded symbol reaches them.
  always_ff @(posedge clk_16 or negedge rst_n) begin
    if (!rst_n) begin
      acos      <= '0;
      bsin      <= '0;
      qam_out   <= '0;
      out_valid <= 1'b0;
    end else if (sym_strobe || out_valid) begin
      acos      <= w_acos;
      bsin      <= w_bsin;
      qam_out   <= w_qam;
      out_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_qam_nmod_mapper.sv
// Directed bench for qam_nmod_mapper: 16-QAM instance (a) and 64-QAM instance (b).
// Expected values switch with QAM_GRAY_EN.
module tb_qam_nmod_mapper;

  logic clk_16 = 1'b0;
  logic rst_n, sync_clr;
  logic bit_in, bit_valid, bit_in_b, bit_valid_b;
  logic signed [11:0] cos_a, sin_a, cos_b, sin_b;
  logic [1:0] bitsa_a, bitsb_a;
  logic [2:0] bitsa_b, bitsb_b;
  logic strobe_a, strobe_b, valid_a, valid_b;
  logic signed [15:0] acos_a, bsin_a, qam_a;
  logic signed [16:0] acos_b, bsin_b, qam_b;

  int errors = 0;
  int checks = 0;

  logic [15:0] t4_bits;
  int t4_acos[4];
  int t4_qam[4];
  int t4_ia[4];

`ifdef QAM_GRAY_EN
  localparam int E1_ACOS = 1025;
  localparam int E1_QAM  = 1001;
  localparam int E1_A100 = 100;
  localparam int E3_BSIN = -24;
  localparam int E3_QAM  = -1001;
  localparam int E6_ACOS = -6144;
  localparam int E6_QAM  = 8185;
`else
  localparam int E1_ACOS = 3075;
  localparam int E1_QAM  = 3051;
  localparam int E1_A100 = 300;
  localparam int E3_BSIN = -8;
  localparam int E3_QAM  = -1017;
  localparam int E6_ACOS = -14336;
  localparam int E6_QAM  = -7;
`endif

  always #5 clk_16 = ~clk_16;

  qam_nmod_mapper u_dut_a (
    .clk_16(clk_16), .rst_n(rst_n), .sync_clr(sync_clr),
    .bit_in(bit_in), .bit_valid(bit_valid), .cos(cos_a), .sin(sin_a),
    .bitsa(bitsa_a), .bitsb(bitsb_a), .sym_strobe(strobe_a),
    .acos(acos_a), .bsin(bsin_a), .qam_out(qam_a), .out_valid(valid_a)
  );

  qam_nmod_mapper #(.BITS_PER_AXIS(3)) u_dut_b (
    .clk_16(clk_16), .rst_n(rst_n), .sync_clr(1'b0),
    .bit_in(bit_in_b), .bit_valid(bit_valid_b), .cos(cos_b), .sin(sin_b),
    .bitsa(bitsa_b), .bitsb(bitsb_b), .sym_strobe(strobe_b),
    .acos(acos_b), .bsin(bsin_b), .qam_out(qam_b), .out_valid(valid_b)
  );

  task automatic tick();
    @(posedge clk_16);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic send_a(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
  endtask

  task automatic send_b(input logic b);
    bit_in_b    = b;
    bit_valid_b = 1'b1;
    tick();
    bit_valid_b = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sync_clr = 1'b0;
    bit_in = 1'b0; bit_valid = 1'b0; bit_in_b = 1'b0; bit_valid_b = 1'b0;
    cos_a = 12'sd1025; sin_a = -12'sd8;
    cos_b = 12'h800;   sin_b = 12'sd2047;
    t4_bits = 16'b1001_0011_1111_0100;
    t4_ia = '{2, 0, 3, 1};
`ifdef QAM_GRAY_EN
    t4_acos = '{3075, -3075, 1025, -1025};
    t4_qam  = '{3067, -3067, 1033, -1049};
`else
    t4_acos = '{1025, -3075, 3075, -1025};
    t4_qam  = '{1017, -3051, 3099, -1049};
`endif

    // Reset state
    tick(); tick();
    chk("rst_bitsa", bitsa_a, 0);
    chk("rst_bitsb", bitsb_a, 0);
    chk("rst_strobe", strobe_a, 0);
    chk("rst_acos", acos_a, 0);
    chk("rst_qam", qam_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_valid_b", valid_b, 0);
    rst_n = 1'b1;
    tick();

    // Test 1: bits 1,1,0,0
    send_a(1'b1); send_a(1'b1); send_a(1'b0); send_a(1'b0);
    tick();
    chk("t1_bitsa", bitsa_a, 3);
    chk("t1_bitsb", bitsb_a, 0);
    chk("t1_strobe", strobe_a, 1);
    chk("t1_valid_pre", valid_a, 0);
    chk("t1_acos_pre", acos_a, 0);
    tick();
    chk("t1_strobe_off", strobe_a, 0);
    chk("t1_valid", valid_a, 1);
    chk("t1_acos", acos_a, E1_ACOS);
    chk("t1_bsin", bsin_a, 24);
    chk("t1_qam", qam_a, E1_QAM);
    cos_a = 12'sd100;
    chk("t1_acos_hold", acos_a, E1_ACOS);
    tick();
    chk("t1_acos_newcar", acos_a, E1_A100);
    cos_a = 12'sd1025;
    tick();

    // Test 3: clear with a bit in flight, then a fresh symbol
    send_a(1'b1); send_a(1'b0);
    sync_clr = 1'b1;
    send_a(1'b1);
    sync_clr = 1'b0;
    chk("t3_valid_kept", valid_a, 1);
    send_a(1'b0);
    chk("t3_no_strobe0", strobe_a, 0);
    send_a(1'b1);
    chk("t3_no_strobe1", strobe_a, 0);
    send_a(1'b1);
    chk("t3_no_strobe2", strobe_a, 0);
    chk("t3_bitsa_held", bitsa_a, 3);
    send_a(1'b0);
    tick();
    chk("t3_strobe", strobe_a, 1);
    chk("t3_bitsa", bitsa_a, 1);
    chk("t3_bitsb", bitsb_a, 2);
    tick();
    chk("t3_acos", acos_a, -1025);
    chk("t3_bsin", bsin_a, E3_BSIN);
    chk("t3_qam", qam_a, E3_QAM);

    // Test 4: four back-to-back symbols, bit_valid held high
    for (int j = 0; j < 18; j++) begin
      if (j < 16) begin
        bit_in    = t4_bits[15 - j];
        bit_valid = 1'b1;
      end else begin
        bit_valid = 1'b0;
      end
      tick();
      chk("t4_strobe", strobe_a, (j >= 4 && j % 4 == 0) ? 1 : 0);
      if (j >= 4 && j % 4 == 0) chk("t4_bitsa", bitsa_a, t4_ia[(j - 4) / 4]);
      if (j >= 5 && j % 4 == 1) begin
        chk("t4_acos", acos_a, t4_acos[(j - 5) / 4]);
        chk("t4_qam", qam_a, t4_qam[(j - 5) / 4]);
      end
    end
    bit_valid = 1'b0;

    // Test 5: reset mid-symbol
    tick();
    send_a(1'b1); send_a(1'b0); send_a(1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_acos", acos_a, 0);
    chk("t5_rst_qam", qam_a, 0);
    chk("t5_rst_valid", valid_a, 0);
    chk("t5_rst_bitsa", bitsa_a, 0);
    tick();
    rst_n = 1'b1;
    tick();
    send_a(1'b0); send_a(1'b1); send_a(1'b1); send_a(1'b0);
    tick();
    chk("t5_strobe", strobe_a, 1);
    chk("t5_bitsa", bitsa_a, 1);
    chk("t5_bitsb", bitsb_a, 2);
    chk("t5_valid_pre", valid_a, 0);
    chk("t5_acos_pre", acos_a, 0);
    tick();
    chk("t5_valid", valid_a, 1);
    chk("t5_acos", acos_a, -1025);
    chk("t5_bsin", bsin_a, E3_BSIN);

    // Test 6: 64-QAM, bits 111000 with full-scale carriers
    send_b(1'b1); send_b(1'b1); send_b(1'b1);
    send_b(1'b0); send_b(1'b0); send_b(1'b0);
    tick();
    chk("t6_bitsa", bitsa_b, 7);
    chk("t6_bitsb", bitsb_b, 0);
    chk("t6_strobe", strobe_b, 1);
    chk("t6_valid_pre", valid_b, 0);
    tick();
    chk("t6_valid", valid_b, 1);
    chk("t6_acos", acos_b, E6_ACOS);
    chk("t6_bsin", bsin_b, -14329);
    chk("t6_qam", qam_b, E6_QAM);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
